// File: rtl/average_extremum_finder_if.sv
// Sample bus and result bus of the extremum finder.
// master: the sample source and result consumer. slave: the finder itself.
interface average_extremum_finder_if #(
    parameter int DATA_W = 16
);
    logic                     period_start;
    logic                     sample_valid;
    logic signed [DATA_W-1:0] average_1_data;
    logic signed [DATA_W-1:0] average_2_data;

    logic [11:0]              average_1_position_max;
    logic [11:0]              average_1_position_min;
    logic [11:0]              average_2_position_max;
    logic [11:0]              average_2_position_min;
    logic                     init_phase_found_posedge;
    logic                     period_abort;
    logic                     scan_busy;

    modport master (
        output period_start, sample_valid, average_1_data, average_2_data,
        input  average_1_position_max, average_1_position_min,
               average_2_position_max, average_2_position_min,
               init_phase_found_posedge, period_abort, scan_busy
    );

    modport slave (
        input  period_start, sample_valid, average_1_data, average_2_data,
        output average_1_position_max, average_1_position_min,
               average_2_position_max, average_2_position_min,
               init_phase_found_posedge, period_abort, scan_busy
    );
endinterface

// File: rtl/average_extremum_finder.sv
// average_extremum_finder: finds the sample index of the maximum and minimum of
// two averaged waveforms over one modulation period and publishes the four
// positions together with a one-cycle strobe.
// Optional feature: define EXTREMUM_DEADBAND_EN to require a sample to beat the
// running extremum by more than DEADBAND LSBs before it takes over.
//
// state | meaning
// IDLE  | waiting for a valid sample flagged period_start
// SCAN  | tracking running max/min of both channels; idx_q = index of next sample
module average_extremum_finder #(
    parameter int PERIOD   = 3600,
    parameter int DATA_W   = 16,
    parameter int DEADBAND = 4
) (
    input logic                      alg_clk,
    input logic                      alg_rst_n,
    average_extremum_finder_if.slave bus
);
    localparam int               POS_W    = 12;
    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(PERIOD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [POS_W-1:0]         idx_q;
    logic signed [DATA_W-1:0] max1_q, min1_q, max2_q, min2_q;
    logic [POS_W-1:0]         max1_pos_q, min1_pos_q, max2_pos_q, min2_pos_q;
    logic [POS_W-1:0]         max1_pos_d, min1_pos_d, max2_pos_d, min2_pos_d;
    logic [POS_W-1:0]         out_max1_q, out_min1_q, out_max2_q, out_min2_q;
    logic                     strobe_q, abort_q;

    logic load, step, publish, abort;
    logic up_max1, up_min1, up_max2, up_min2;

`ifdef EXTREMUM_DEADBAND_EN
    // One extra bit so running_max + margin / running_min - margin cannot wrap.
    localparam logic signed [DATA_W:0] MARGIN = (DATA_W+1)'(DEADBAND);

    function automatic logic beats_max(input logic signed [DATA_W-1:0] s,
                                       input logic signed [DATA_W-1:0] r);
        logic signed [DATA_W:0] s_x, r_x;
        s_x = {s[DATA_W-1], s};
        r_x = {r[DATA_W-1], r};
        return s_x > (r_x + MARGIN);
    endfunction

    function automatic logic beats_min(input logic signed [DATA_W-1:0] s,
                                       input logic signed [DATA_W-1:0] r);
        logic signed [DATA_W:0] s_x, r_x;
        s_x = {s[DATA_W-1], s};
        r_x = {r[DATA_W-1], r};
        return s_x < (r_x - MARGIN);
    endfunction
`else
    // Strict compare: ties keep the earlier position.
    function automatic logic beats_max(input logic signed [DATA_W-1:0] s,
                                       input logic signed [DATA_W-1:0] r);
        return s > r;
    endfunction

    function automatic logic beats_min(input logic signed [DATA_W-1:0] s,
                                       input logic signed [DATA_W-1:0] r);
        return s < r;
    endfunction

    logic unused_deadband;
    assign unused_deadband = ^DEADBAND;
`endif

    // State register.
    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next state and per-cycle sequencing decisions.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        publish = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.sample_valid && bus.period_start) begin
                    load    = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.sample_valid) begin
                    if (bus.period_start) begin
                        load  = 1'b1;
                        abort = 1'b1;
                    end else begin
                        step = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            publish = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Replacement decisions and next running positions (final sample included).
    always_comb begin
        up_max1    = step && beats_max(bus.average_1_data, max1_q);
        up_min1    = step && beats_min(bus.average_1_data, min1_q);
        up_max2    = step && beats_max(bus.average_2_data, max2_q);
        up_min2    = step && beats_min(bus.average_2_data, min2_q);
        max1_pos_d = load ? '0 : (up_max1 ? idx_q : max1_pos_q);
        min1_pos_d = load ? '0 : (up_min1 ? idx_q : min1_pos_q);
        max2_pos_d = load ? '0 : (up_max2 ? idx_q : max2_pos_q);
        min2_pos_d = load ? '0 : (up_min2 ? idx_q : min2_pos_q);
    end

    // Running extremum values, positions and sample index.
    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) begin
            idx_q      <= '0;
            max1_q     <= '0;
            min1_q     <= '0;
            max2_q     <= '0;
            min2_q     <= '0;
            max1_pos_q <= '0;
            min1_pos_q <= '0;
            max2_pos_q <= '0;
            min2_pos_q <= '0;
        end else begin
            if (load) begin
                max1_q <= bus.average_1_data;
                min1_q <= bus.average_1_data;
                max2_q <= bus.average_2_data;
                min2_q <= bus.average_2_data;
                idx_q  <= POS_W'(1);
            end else if (step) begin
                if (up_max1) max1_q <= bus.average_1_data;
                if (up_min1) min1_q <= bus.average_1_data;
                if (up_max2) max2_q <= bus.average_2_data;
                if (up_min2) min2_q <= bus.average_2_data;
                idx_q <= publish ? '0 : idx_q + POS_W'(1);
            end
            max1_pos_q <= max1_pos_d;
            min1_pos_q <= min1_pos_d;
            max2_pos_q <= max2_pos_d;
            min2_pos_q <= min2_pos_d;
        end
    end

    // Published positions and strobes; positions and strobe move on the same edge.
    always_ff @(posedge alg_clk or negedge alg_rst_n) begin
        if (!alg_rst_n) begin
            out_max1_q <= '0;
            out_min1_q <= '0;
            out_max2_q <= '0;
            out_min2_q <= '0;
            strobe_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            if (publish) begin
                out_max1_q <= max1_pos_d;
                out_min1_q <= min1_pos_d;
                out_max2_q <= max2_pos_d;
                out_min2_q <= min2_pos_d;
            end
            strobe_q <= publish;
            abort_q  <= abort;
        end
    end

    assign bus.average_1_position_max   = out_max1_q;
    assign bus.average_1_position_min   = out_min1_q;
    assign bus.average_2_position_max   = out_max2_q;
    assign bus.average_2_position_min   = out_min2_q;
    assign bus.init_phase_found_posedge = strobe_q;
    assign bus.period_abort             = abort_q;
    assign bus.scan_busy                = (state_q == SCAN);
endmodule

// File: tb/tb_average_extremum_finder.sv
// Testbench for average_extremum_finder: table-driven waveform records, directed
// sine/restart/gap/reset sequences and randomized periods, all checked against a
// queue-based reference model of one period.
module tb_average_extremum_finder;
    localparam int PERIOD = 3600;
    localparam int DW     = 16;
    localparam int DB     = 4;
    localparam real PI    = 3.14159265358979323846;

    logic alg_clk   = 1'b0;
    logic alg_rst_n = 1'b0;

    average_extremum_finder_if #(.DATA_W(DW)) bus ();

    average_extremum_finder #(.PERIOD(PERIOD), .DATA_W(DW), .DEADBAND(DB)) dut (
        .alg_clk  (alg_clk),
        .alg_rst_n(alg_rst_n),
        .bus      (bus)
    );

    always #5 alg_clk = ~alg_clk;

    typedef struct {
        int hi1_a, hi1_b, lo1_a, lo1_b;
        int hi2_a, hi2_b, lo2_a, lo2_b;
        int e_max1, e_min1, e_max2, e_min2;
    } vec_t;
    vec_t vt[3];

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit m_scan = 1'b0;
    int m_q1[$];
    int m_q2[$];
    int exp_pos[4] = '{0, 0, 0, 0};
    bit exp_strobe = 1'b0;
    bit exp_abort  = 1'b0;
    bit busy_seen  = 1'b0;
    int m_pubs = 0, m_aborts = 0;
    int obs_strobes = 0, obs_aborts = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_pos(input string name, input int e0, input int e1, input int e2, input int e3);
        chk({name, " ch1 max"}, bus.average_1_position_max, e0);
        chk({name, " ch1 min"}, bus.average_1_position_min, e1);
        chk({name, " ch2 max"}, bus.average_2_position_max, e2);
        chk({name, " ch2 min"}, bus.average_2_position_min, e3);
    endtask

    function automatic int sinv(input int n, input bit cosine);
        real x, y;
        x = real'(n) * PI / 1800.0;
        y = 1000.0 * (cosine ? $cos(x) : $sin(x));
        return $rtoi(y + ((y >= 0.0) ? 1.0e-6 : -1.0e-6));
    endfunction

    function automatic int tbl_val(input int n, input int hi_a, input int hi_b,
                                   input int lo_a, input int lo_b);
        if (n == hi_a || n == hi_b) return 500;
        if (n == lo_a || n == lo_b) return -500;
        return 7;
    endfunction

    function automatic int rnd();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    // Position of the period's extremum from the whole buffered period.
    function automatic int arg_ext(input int q[$], input bit want_max);
`ifdef EXTREMUM_DEADBAND_EN
        int best, pos;
        best = q[0];
        pos  = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (want_max ? (q[i] > best + DB) : (q[i] < best - DB)) begin
                best = q[i];
                pos  = i;
            end
        end
        return pos;
`else
        int ext;
        ext = q[0];
        foreach (q[i]) if (want_max ? (q[i] > ext) : (q[i] < ext)) ext = q[i];
        foreach (q[i]) if (q[i] == ext) return i;
        return 0;
`endif
    endfunction

    task automatic model_step(input bit ps, input int a, input int b);
        if (ps) begin
            if (m_scan) begin
                exp_abort = 1'b1;
                m_aborts++;
            end
            m_q1.delete();
            m_q2.delete();
            m_q1.push_back(a);
            m_q2.push_back(b);
            m_scan = 1'b1;
        end else if (m_scan) begin
            m_q1.push_back(a);
            m_q2.push_back(b);
            if (m_q1.size() == PERIOD) begin
                exp_pos[0] = arg_ext(m_q1, 1'b1);
                exp_pos[1] = arg_ext(m_q1, 1'b0);
                exp_pos[2] = arg_ext(m_q2, 1'b1);
                exp_pos[3] = arg_ext(m_q2, 1'b0);
                exp_strobe = 1'b1;
                m_pubs++;
                m_scan = 1'b0;
            end
        end
    endtask

    // Compares the outputs produced by the previous cycle's sample.
    task automatic check_step();
        if (bus.init_phase_found_posedge) obs_strobes++;
        if (bus.period_abort) obs_aborts++;
        if (exp_strobe || bus.init_phase_found_posedge) begin
            chk("strobe", bus.init_phase_found_posedge, exp_strobe);
            chk_pos("published", exp_pos[0], exp_pos[1], exp_pos[2], exp_pos[3]);
        end
        if (exp_abort || bus.period_abort) chk("abort", bus.period_abort, exp_abort);
        if (bus.scan_busy !== m_scan || m_scan != busy_seen) begin
            chk("scan_busy", bus.scan_busy, m_scan);
            busy_seen = m_scan;
        end
        exp_strobe = 1'b0;
        exp_abort  = 1'b0;
    endtask

    task automatic put(input bit v, input bit ps, input int a, input int b);
        @(negedge alg_clk);
        check_step();
        bus.sample_valid   = v;
        bus.period_start   = ps;
        bus.average_1_data = DW'(a);
        bus.average_2_data = DW'(b);
        if (v) model_step(ps, a, b);
    endtask

    task automatic run_sine(input int start_n, input int pct_valid);
        int n, guard;
        n = 0;
        guard = 0;
        while (n < PERIOD && guard < 4 * PERIOD) begin
            guard++;
            if ($urandom_range(99) < pct_valid) begin
                put(1'b1, n == 0, sinv(start_n + n, 1'b0), sinv(start_n + n, 1'b1));
                n++;
            end else begin
                put(1'b0, 1'($urandom), rnd(), rnd());
            end
        end
        put(1'b0, 1'b0, 0, 0);
        if (n < PERIOD) chk("sine sample budget", n, PERIOD);
    endtask

    task automatic async_reset();
        @(negedge alg_clk);
        bus.sample_valid = 1'b0;
        bus.period_start = 1'b0;
        #2 alg_rst_n = 1'b0;
        #1;
        chk_pos("async reset", 0, 0, 0, 0);
        chk("async reset busy", bus.scan_busy, 0);
        chk("async reset strobe", bus.init_phase_found_posedge, 0);
        m_scan = 1'b0;
        m_q1.delete();
        m_q2.delete();
        exp_pos    = '{0, 0, 0, 0};
        exp_strobe = 1'b0;
        exp_abort  = 1'b0;
        busy_seen  = 1'b0;
        @(negedge alg_clk);
        #2 alg_rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int st0, ab0;
        vt[0] = '{100, 3000, 50, 3500, 3599, -1, 0, -1, 100, 50, 3599, 0};
        vt[1] = '{-1, -1, -1, -1, -1, -1, -1, -1, 0, 0, 0, 0};
        vt[2] = '{1, 2, 3599, 3598, 1799, -1, 1800, -1, 1, 3598, 1799, 1800};

        bus.sample_valid   = 1'b0;
        bus.period_start   = 1'b0;
        bus.average_1_data = '0;
        bus.average_2_data = '0;

        #3;
        chk_pos("reset", 0, 0, 0, 0);
        chk("reset strobe", bus.init_phase_found_posedge, 0);
        chk("reset abort", bus.period_abort, 0);
        chk("reset busy", bus.scan_busy, 0);
        #20 alg_rst_n = 1'b1;

        // table-driven waveform records: ties, constant data, end-of-period extrema
        foreach (vt[t]) begin
            for (int n = 0; n < PERIOD; n++)
                put(1'b1, n == 0,
                    tbl_val(n, vt[t].hi1_a, vt[t].hi1_b, vt[t].lo1_a, vt[t].lo1_b),
                    tbl_val(n, vt[t].hi2_a, vt[t].hi2_b, vt[t].lo2_a, vt[t].lo2_b));
            put(1'b0, 1'b0, 0, 0);
            chk($sformatf("vec%0d ch1 max", t), bus.average_1_position_max, vt[t].e_max1);
            chk($sformatf("vec%0d ch1 min", t), bus.average_1_position_min, vt[t].e_min1);
            chk($sformatf("vec%0d ch2 max", t), bus.average_2_position_max, vt[t].e_max2);
            chk($sformatf("vec%0d ch2 min", t), bus.average_2_position_min, vt[t].e_min2);
        end

        // sine / cosine, continuous valid
        run_sine(0, 100);
`ifndef EXTREMUM_DEADBAND_EN
        chk_pos("sine", 900, 2700, 0, 1800);
`endif

        // restart mid-scan at sample 2000
        st0 = obs_strobes;
        ab0 = obs_aborts;
        for (int n = 0; n < 2000; n++) put(1'b1, n == 0, sinv(n, 1'b0), sinv(n, 1'b1));
        put(1'b1, 1'b1, sinv(2000, 1'b0), sinv(2000, 1'b1));
        put(1'b0, 1'b0, 0, 0);
        chk("restart abort count", obs_aborts - ab0, 1);
        chk("restart no strobe", obs_strobes - st0, 0);
        chk_pos("restart hold", exp_pos[0], exp_pos[1], exp_pos[2], exp_pos[3]);
        for (int k = 1; k < PERIOD; k++) put(1'b1, 1'b0, sinv(2000 + k, 1'b0), sinv(2000 + k, 1'b1));
        put(1'b0, 1'b0, 0, 0);
        chk("restart strobe count", obs_strobes - st0, 1);
`ifndef EXTREMUM_DEADBAND_EN
        chk_pos("restart", 2500, 700, 1600, 3400);
`endif

        // gapped valid, garbage data and period_start while invalid
        st0 = obs_strobes;
        run_sine(0, 50);
        chk("gapped strobe count", obs_strobes - st0, 1);
`ifndef EXTREMUM_DEADBAND_EN
        chk_pos("gapped", 900, 2700, 0, 1800);
`endif

        // asynchronous reset mid-scan, then samples without period_start are ignored
        for (int n = 0; n < 1200; n++) put(1'b1, n == 0, sinv(n, 1'b0), sinv(n, 1'b1));
        async_reset();
        st0 = obs_strobes;
        for (int n = 1200; n < 1500; n++) put(1'b1, 1'b0, sinv(n, 1'b0), sinv(n, 1'b1));
        put(1'b0, 1'b0, 0, 0);
        chk("post-reset ignored strobes", obs_strobes - st0, 0);
        chk("post-reset busy", bus.scan_busy, 0);
        chk_pos("post-reset", 0, 0, 0, 0);
        run_sine(0, 100);
`ifndef EXTREMUM_DEADBAND_EN
        chk_pos("after reset", 900, 2700, 0, 1800);
`endif

        // randomized periods, one with a random restart
        for (int t = 0; t < 3; t++) begin
            int guard, sent, inj;
            inj   = (t == 1) ? int'($urandom_range(PERIOD - 2, 1)) : -1;
            put(1'b1, 1'b1, rnd(), rnd());
            sent  = 1;
            guard = 0;
            while (m_scan && guard < 3 * PERIOD) begin
                guard++;
                if ($urandom_range(3) != 0) begin
                    put(1'b1, sent == inj, rnd(), rnd());
                    sent++;
                end else begin
                    put(1'b0, 1'($urandom), rnd(), rnd());
                end
            end
            put(1'b0, 1'b0, 0, 0);
            chk($sformatf("random%0d finished", t), bus.scan_busy, 0);
        end

`ifdef EXTREMUM_DEADBAND_EN
        // deadband: a late peak must exceed the running max by more than DB
        for (int t = 0; t < 2; t++) begin
            int late;
            late = (t == 0) ? 1003 : 1005;
            for (int n = 0; n < PERIOD; n++)
                put(1'b1, n == 0, (n == 900) ? 1000 : ((n == 950) ? late : 0), 0);
            put(1'b0, 1'b0, 0, 0);
            chk($sformatf("deadband late=%0d", late), bus.average_1_position_max, (t == 0) ? 900 : 950);
        end
`endif

        chk("total strobes", obs_strobes, m_pubs);
        chk("total aborts", obs_aborts, m_aborts);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
